pr_update_scheduler: RTL and testbench
======================================

Name: pr_update_scheduler

Overview:
Buffers branch-predictor update packets from the two commit ports and issues them one per cycle to the BTB/predictor write port, with a valid/ready handshake. Sits between commit and the IF-stage predictor. Sequences BTB invalidation: it flushes pending updates and blocks traffic while the BTB clears.

Parameters:
DEPTH, 8, update queue entries (power of 2, >=4)
INV_CYCLES, 4, cycles the BTB needs to complete an invalidate
UPD_W, 72, packed update width: {valid_jump, jump_taken, is_comp, rat_id[1:0], orig_pc[31:0], jump_address[31:0], ticket[2:0]}, MSB first

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
upd_valid_i  in  2  per commit port update valid
upd_data0_i  in  UPD_W  commit port 0 update
upd_data1_i  in  UPD_W  commit port 1 update (younger than port 0)
upd_ready_o  out  2  per-port accept
out_valid_o  out  1  update available to predictor
out_data_o  out  UPD_W  head update
out_ready_i  in  1  predictor accepts update
btb_inv_i  in  1  BTB invalidate request (pulse or level)
busy_o  out  1  state==INV
count_o  out  $clog2(DEPTH)+1  queued entries
drop_cnt_o  out  16  saturating count of discarded updates

Behaviour:
- Reset (async, rst_n=0): count=0, head=tail=0, state=RUN, inv counter=0, drop_cnt=0.
- Reset outputs: out_valid_o=0, upd_ready_o=2'b00 while rst_n=0, busy_o=0, count_o=0, drop_cnt_o=0.
- Reset mid-operation clears all state immediately. No partial entries survive.
- States: RUN, INV.
  - RUN->INV on btb_inv_i=1; load inv counter = INV_CYCLES-1.
  - INV: decrement each cycle. btb_inv_i=1 in INV reloads the counter.
  - INV->RUN when the counter is 0 and btb_inv_i=0.
- Ready (combinational from registered count):
  - upd_ready_o[0] = RUN & !btb_inv_i & (DEPTH-count >= 1).
  - upd_ready_o[1] = RUN & !btb_inv_i & (DEPTH-count >= 2).
  - A same-cycle pop does not raise ready.
- Push: a port is accepted when its valid and ready are both 1.
  - If both are accepted, port 0 is written at tail and port 1 at tail+1. tail advances by the number accepted, mod DEPTH.
  - If only port 1 is valid, it is written at tail.
- Output:
  - out_valid_o = RUN & !btb_inv_i & (count!=0).
  - out_data_o = entry[head].
  - Pop on out_valid_o & out_ready_i; head advances mod DEPTH.
  - out_data_o must hold stable while out_valid_o=1 and out_ready_i=0.
- Count update: count_next = count + pushes - pop, all in the same cycle. count never exceeds DEPTH and never underflows.
- Latency: an update pushed in cycle N into an empty queue appears on out_valid_o in cycle N+1. There is no same-cycle bypass.
- Invalidate: the cycle btb_inv_i is sampled 1 in RUN:
  - count->0 and head=tail.
  - drop_cnt += count (saturate at 0xFFFF).
  - No push or pop occurs that cycle.
- Ordering: updates are issued strictly in acceptance order (port 0 before port 1 within a cycle).
- The valid_jump bit is passed through unmodified. The scheduler does not filter on it.

Optional Feature:
UPD_COALESCE_EN:
- When defined, an accepted update is merged instead of allocated if:
  - its orig_pc equals the newest queued entry's orig_pc, and
  - count>=2 (the entry is not the head), and
  - no pop of that entry occurs the same cycle.
- On a merge, the newer data overwrites that entry in place, the slot is not consumed, and drop_cnt_o increments by 1.
- When both ports share the same orig_pc, the port 1 update overwrites the port 0 update.
- Without the macro, every accepted update allocates a slot and there is no orig_pc comparison logic.

Test Plan:
- Reset, then one push on port 0 with orig_pc=0x100 -> out_valid_o=1 next cycle, out_data_o orig_pc=0x100, count_o=1; pop with out_ready_i=1 -> count_o=0.
- Dual push every cycle with out_ready_i=0 -> count_o: 2,4,6,8. At count 7, upd_ready_o=2'b01. At 8, upd_ready_o=2'b00. Drain yields pushed order, port 0 first.
- Queue count=5, assert btb_inv_i for 1 cycle -> count_o=0, drop_cnt_o=5, busy_o=1 for 4 cycles, upd_ready_o=0 and out_valid_o=0 throughout; RUN resumes on cycle 5.
- Fill/drain 20 entries continuously with one push and one pop per cycle -> head/tail wrap; all 20 issued in order; count_o stays 1.
- Assert rst_n=0 mid-drain at count=3 -> all outputs return to reset values immediately; first post-reset push is issued alone.
- With UPD_COALESCE_EN, queue orig_pc 0x10, 0x20, then push orig_pc 0x20 with ticket=5 -> count_o stays 2, drop_cnt_o=1, second issued entry carries ticket=5.

Source files
------------

// File: rtl/pr_update_scheduler.sv
// Branch-predictor update scheduler: merges two commit ports into a FIFO drained one per cycle,
// with BTB invalidate sequencing. Optional feature macro: UPD_COALESCE_EN (same-PC update merge).
module pr_update_scheduler #(
    parameter int DEPTH      = 8,
    parameter int INV_CYCLES = 4,
    parameter int UPD_W      = 72
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 upd_valid_i,
    input  logic [UPD_W-1:0]           upd_data0_i,
    input  logic [UPD_W-1:0]           upd_data1_i,
    output logic [1:0]                 upd_ready_o,
    output logic                       out_valid_o,
    output logic [UPD_W-1:0]           out_data_o,
    input  logic                       out_ready_i,
    input  logic                       btb_inv_i,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = (INV_CYCLES > 1) ? $clog2(INV_CYCLES) : 1;
`ifdef UPD_COALESCE_EN
    localparam int PC_LSB = 35;
    localparam int PC_MSB = 66;
`endif

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_INV = 1'b1
    } state_t;

    state_t              state_r;
    logic [IW-1:0]       inv_cnt_r;
    logic [AW-1:0]       head_r;
    logic [AW-1:0]       tail_r;
    logic [CW-1:0]       count_r;
    logic [15:0]         drop_r;
    logic [UPD_W-1:0]    mem_r [DEPTH];

    logic                run_s;
    logic                inv_take_s;
    logic [CW-1:0]       free_s;
    logic [1:0]          ready_s;
    logic                acc0_s;
    logic                acc1_s;
    logic                out_valid_s;
    logic                pop_s;
    logic                merge0_s;
    logic                merge1_s;
    logic [AW-1:0]       wr0_idx_s;
    logic [AW-1:0]       wr1_idx_s;
    logic [CW-1:0]       alloc_s;
    logic [CW-1:0]       merge_cnt_s;
    logic [CW-1:0]       count_next_s;
`ifdef UPD_COALESCE_EN
    logic                can_merge_s;
    logic [AW-1:0]       newest_idx_s;
    logic [31:0]         newest_pc_s;
`endif

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Handshake qualification: traffic only flows in RUN with no invalidate pending this cycle.
    always_comb begin
        run_s       = (state_r == ST_RUN) && !btb_inv_i;
        inv_take_s  = (state_r == ST_RUN) && btb_inv_i;
        free_s      = CW'(DEPTH) - count_r;
        ready_s[0]  = rst_n && run_s && (free_s >= CW'(1));
        ready_s[1]  = rst_n && run_s && (free_s >= CW'(2));
        acc0_s      = upd_valid_i[0] && ready_s[0];
        acc1_s      = upd_valid_i[1] && ready_s[1];
        out_valid_s = run_s && (count_r != '0);
        pop_s       = out_valid_s && out_ready_i;
    end

    // Slot selection for accepted updates; merges redirect a write onto an existing slot.
    always_comb begin
        wr0_idx_s = tail_r;
        wr1_idx_s = tail_r + AW'(acc0_s);
        merge0_s  = 1'b0;
        merge1_s  = 1'b0;
`ifdef UPD_COALESCE_EN
        // With two or more entries the newest one is never the head, so it cannot be popped now.
        can_merge_s  = (count_r >= CW'(2));
        newest_idx_s = tail_r - AW'(1'b1);
        newest_pc_s  = mem_r[newest_idx_s][PC_MSB:PC_LSB];
        if (acc0_s && can_merge_s && (upd_data0_i[PC_MSB:PC_LSB] == newest_pc_s)) begin
            merge0_s  = 1'b1;
            wr0_idx_s = newest_idx_s;
        end else begin
            merge0_s  = 1'b0;
            wr0_idx_s = tail_r;
        end
        if (acc1_s && acc0_s && (upd_data1_i[PC_MSB:PC_LSB] == upd_data0_i[PC_MSB:PC_LSB])) begin
            merge1_s  = 1'b1;
            wr1_idx_s = wr0_idx_s;
        end else if (acc1_s && !acc0_s && can_merge_s &&
                     (upd_data1_i[PC_MSB:PC_LSB] == newest_pc_s)) begin
            merge1_s  = 1'b1;
            wr1_idx_s = newest_idx_s;
        end else begin
            merge1_s  = 1'b0;
            wr1_idx_s = tail_r + AW'(acc0_s && !merge0_s);
        end
`endif
        alloc_s      = CW'(acc0_s && !merge0_s) + CW'(acc1_s && !merge1_s);
        merge_cnt_s  = CW'(merge0_s) + CW'(merge1_s);
        count_next_s = count_r + alloc_s - CW'(pop_s);
    end

    // Invalidate sequencer: hold INV until the counter expires with no request outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            inv_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (btb_inv_i) begin
                        state_r   <= ST_INV;
                        inv_cnt_r <= IW'(INV_CYCLES - 1);
                    end
                end
                ST_INV: begin
                    if (btb_inv_i) begin
                        inv_cnt_r <= IW'(INV_CYCLES - 1);
                    end else if (inv_cnt_r == '0) begin
                        state_r <= ST_RUN;
                    end else begin
                        inv_cnt_r <= inv_cnt_r - IW'(1'b1);
                    end
                end
                default: begin
                    state_r   <= ST_RUN;
                    inv_cnt_r <= '0;
                end
            endcase
        end
    end

    // Queue storage, pointers, occupancy and discard accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            drop_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (inv_take_s) begin
            head_r  <= tail_r;
            count_r <= '0;
            drop_r  <= sat_add16(drop_r, count_r);
        end else begin
            if (acc0_s) begin
                mem_r[wr0_idx_s] <= upd_data0_i;
            end
            // Port 1 is written last so it wins when both target the same slot.
            if (acc1_s) begin
                mem_r[wr1_idx_s] <= upd_data1_i;
            end
            tail_r  <= tail_r + alloc_s[AW-1:0];
            head_r  <= head_r + AW'(pop_s);
            count_r <= count_next_s;
            drop_r  <= sat_add16(drop_r, merge_cnt_s);
        end
    end

    assign upd_ready_o = ready_s;
    assign out_valid_o = out_valid_s;
    assign out_data_o  = mem_r[head_r];
    assign busy_o      = (state_r == ST_INV);
    assign count_o     = count_r;
    assign drop_cnt_o  = drop_r;

endmodule

// File: tb/tb_pr_update_scheduler.sv
// Directed self-checking bench for pr_update_scheduler (default DEPTH=8, INV_CYCLES=4).
module tb_pr_update_scheduler;

    logic         clk;
    logic         rst_n;
    logic [1:0]   upd_valid_i;
    logic [71:0]  upd_data0_i;
    logic [71:0]  upd_data1_i;
    logic [1:0]   upd_ready_o;
    logic         out_valid_o;
    logic [71:0]  out_data_o;
    logic         out_ready_i;
    logic         btb_inv_i;
    logic         busy_o;
    logic [3:0]   count_o;
    logic [15:0]  drop_cnt_o;

    int checks;
    int errors;
    logic [71:0] exp_q [8];

    pr_update_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_valid_i (upd_valid_i),
        .upd_data0_i (upd_data0_i),
        .upd_data1_i (upd_data1_i),
        .upd_ready_o (upd_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .btb_inv_i   (btb_inv_i),
        .busy_o      (busy_o),
        .count_o     (count_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [31:0] pc, input logic [2:0] ticket);
        return {1'b1, 1'b0, 1'b0, 2'b01, pc, pc + 32'd4, ticket};
    endfunction

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        upd_valid_i = 2'b00;
        upd_data0_i = '0;
        upd_data1_i = '0;
        out_ready_i = 1'b0;
        btb_inv_i   = 1'b0;
        #2;
        check_eq("rst_out_valid", 72'(out_valid_o), 72'd0);
        check_eq("rst_ready", 72'(upd_ready_o), 72'd0);
        check_eq("rst_busy", 72'(busy_o), 72'd0);
        check_eq("rst_count", 72'(count_o), 72'd0);
        check_eq("rst_drop", 72'(drop_cnt_o), 72'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single push, one-cycle latency, then pop.
        upd_valid_i = 2'b01;
        upd_data0_i = mk(32'h100, 3'd1);
        #1;
        check_eq("t1_ready_empty", 72'(upd_ready_o), 72'd3);
        check_eq("t1_no_bypass", 72'(out_valid_o), 72'd0);
        cyc();
        upd_valid_i = 2'b00;
        #1;
        check_eq("t1_valid", 72'(out_valid_o), 72'd1);
        check_eq("t1_data", out_data_o, mk(32'h100, 3'd1));
        check_eq("t1_count", 72'(count_o), 72'd1);
        out_ready_i = 1'b1;
        cyc();
        out_ready_i = 1'b0;
        #1;
        check_eq("t1_count_pop", 72'(count_o), 72'd0);
        check_eq("t1_valid_pop", 72'(out_valid_o), 72'd0);

        // Dual push to full, then drain in order.
        for (int k = 0; k < 4; k++) begin
            exp_q[2*k]   = mk(32'h200 + 32'(8*k), 3'(2*k));
            exp_q[2*k+1] = mk(32'h204 + 32'(8*k), 3'(2*k+1));
            upd_data0_i  = exp_q[2*k];
            upd_data1_i  = exp_q[2*k+1];
            upd_valid_i  = 2'b11;
            #1;
            check_eq("t2_ready_fill", 72'(upd_ready_o), 72'd3);
            cyc();
            check_eq("t2_count_fill", 72'(count_o), 72'(2*(k+1)));
        end
        upd_valid_i = 2'b00;
        out_ready_i = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check_eq("t2_drain_data", out_data_o, exp_q[i]);
            if (i == 0) check_eq("t2_ready_full", 72'(upd_ready_o), 72'd0);
            if (i == 1) check_eq("t2_ready_seven", 72'(upd_ready_o), 72'd1);
            cyc();
        end
        out_ready_i = 1'b0;
        #1;
        check_eq("t2_count_empty", 72'(count_o), 72'd0);

        // Invalidate with five queued entries.
        upd_valid_i = 2'b11;
        upd_data0_i = mk(32'h400, 3'd0);
        upd_data1_i = mk(32'h404, 3'd1);
        cyc();
        cyc();
        upd_valid_i = 2'b01;
        cyc();
        upd_valid_i = 2'b00;
        #1;
        check_eq("t3_count5", 72'(count_o), 72'd5);
        btb_inv_i   = 1'b1;
        upd_valid_i = 2'b11;
        out_ready_i = 1'b1;
        #1;
        check_eq("t3_inv_ready", 72'(upd_ready_o), 72'd0);
        check_eq("t3_inv_valid", 72'(out_valid_o), 72'd0);
        cyc();
        btb_inv_i = 1'b0;
        #1;
        check_eq("t3_count0", 72'(count_o), 72'd0);
        check_eq("t3_drop5", 72'(drop_cnt_o), 72'd5);
        for (int k = 0; k < 4; k++) begin
            check_eq("t3_busy", 72'(busy_o), 72'd1);
            check_eq("t3_blocked_ready", 72'(upd_ready_o), 72'd0);
            check_eq("t3_blocked_valid", 72'(out_valid_o), 72'd0);
            check_eq("t3_blocked_count", 72'(count_o), 72'd0);
            cyc();
        end
        upd_valid_i = 2'b00;
        out_ready_i = 1'b0;
        #1;
        check_eq("t3_run_busy", 72'(busy_o), 72'd0);
        check_eq("t3_run_ready", 72'(upd_ready_o), 72'd3);

        // Streaming 20 entries through with wrap.
        out_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            upd_valid_i = 2'b01;
            upd_data0_i = mk(32'h1000 + 32'(4*i), 3'(i));
            #1;
            if (i > 0) begin
                check_eq("t4_count", 72'(count_o), 72'd1);
                check_eq("t4_data", out_data_o, mk(32'h1000 + 32'(4*(i-1)), 3'(i-1)));
            end
            cyc();
        end
        upd_valid_i = 2'b00;
        #1;
        check_eq("t4_last_data", out_data_o, mk(32'h1000 + 32'(4*19), 3'd3));
        cyc();
        check_eq("t4_count_end", 72'(count_o), 72'd0);

        // Reset mid-drain at count 3.
        out_ready_i = 1'b0;
        upd_valid_i = 2'b11;
        upd_data0_i = mk(32'h500, 3'd0);
        upd_data1_i = mk(32'h504, 3'd1);
        cyc();
        cyc();
        upd_valid_i = 2'b00;
        out_ready_i = 1'b1;
        cyc();
        check_eq("t5_count3", 72'(count_o), 72'd3);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", 72'(out_valid_o), 72'd0);
        check_eq("t5_rst_ready", 72'(upd_ready_o), 72'd0);
        check_eq("t5_rst_count", 72'(count_o), 72'd0);
        check_eq("t5_rst_drop", 72'(drop_cnt_o), 72'd0);
        check_eq("t5_rst_busy", 72'(busy_o), 72'd0);
        cyc();
        rst_n       = 1'b1;
        upd_valid_i = 2'b01;
        upd_data0_i = mk(32'h300, 3'd3);
        cyc();
        upd_valid_i = 2'b00;
        #1;
        check_eq("t5_post_valid", 72'(out_valid_o), 72'd1);
        check_eq("t5_post_data", out_data_o, mk(32'h300, 3'd3));
        check_eq("t5_post_count", 72'(count_o), 72'd1);
        cyc();
        check_eq("t5_alone_count", 72'(count_o), 72'd0);
        check_eq("t5_alone_valid", 72'(out_valid_o), 72'd0);

`ifdef UPD_COALESCE_EN
        // Same-PC update merges into the newest non-head entry.
        out_ready_i = 1'b0;
        upd_valid_i = 2'b01;
        upd_data0_i = mk(32'h10, 3'd1);
        cyc();
        upd_data0_i = mk(32'h20, 3'd2);
        cyc();
        upd_data0_i = mk(32'h20, 3'd5);
        cyc();
        upd_valid_i = 2'b00;
        #1;
        check_eq("t6_count", 72'(count_o), 72'd2);
        check_eq("t6_drop", 72'(drop_cnt_o), 72'd1);
        out_ready_i = 1'b1;
        #1;
        check_eq("t6_first", out_data_o, mk(32'h10, 3'd1));
        cyc();
        check_eq("t6_second", out_data_o, mk(32'h20, 3'd5));
        cyc();
        out_ready_i = 1'b0;
        #1;
        check_eq("t6_count_end", 72'(count_o), 72'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
